filter_ctrl: RTL
================

FILTER_CTRL -- requirements
Module: filter_ctrl

Interface
REQ-001 SHALL have parameter FILT_SIZE, default 4, filter rows/cols loaded and scanned (legal 1..4).
REQ-002 SHALL have parameter ADDR_W, default 16, memory word-address width.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to load and scan a filter.
REQ-006 SHALL have port reuse  input  1  sampled with start; skip load (see Configuration).
REQ-007 SHALL have port base_addr  input  ADDR_W  address of filter row 0, sampled with start.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse after last element accepted.
REQ-010 SHALL have port mem_rd  output  1  one-cycle read request.
REQ-011 SHALL have port mem_addr  output  ADDR_W  read address, valid with mem_rd.
REQ-012 SHALL have port mem_valid  input  1  read data (32-bit row word) present at the filter buffer's data input.
REQ-013 SHALL have port fb_ld  output  1  filter buffer row load strobe.
REQ-014 SHALL have port fb_row  output  2  filter buffer row select (load and scan).
REQ-015 SHALL have port fb_col  output  2  filter buffer column select (scan).
REQ-016 SHALL have port elem_valid  output  1  filter buffer data_out is the current scan element.
REQ-017 SHALL have port elem_ready  input  1  consumer accepts element when high with elem_valid.
REQ-018 SHALL have port elem_last  output  1  current element is (FILT_SIZE-1, FILT_SIZE-1).

Function
REQ-019 SHALL implement states IDLE, LOAD_REQ, LOAD_WAIT, SCAN, DONE.
REQ-020 IDLE: start=1 SHALL capture base_addr, clear row/col counters, go LOAD_REQ (or SCAN per REQ-031).
REQ-021 LOAD_REQ: SHALL assert mem_rd for exactly one cycle with mem_addr = base + row (mod 2^ADDR_W), then go LOAD_WAIT.
REQ-022 LOAD_WAIT: on mem_valid SHALL assert fb_ld combinationally that cycle with fb_row = row; if row = FILT_SIZE-1 go SCAN with row=col=0, else row+1 and go LOAD_REQ.
REQ-023 LOAD_WAIT SHALL wait indefinitely for mem_valid; mem_valid in any other state SHALL be ignored (no fb_ld).
REQ-024 SCAN: elem_valid SHALL be 1, fb_row/fb_col = counters; counters SHALL hold while elem_ready=0.
REQ-025 SCAN advance on elem_ready: col increments; col = FILT_SIZE-1 wraps to 0 and row increments (row-major).
REQ-026 Acceptance with elem_last=1 SHALL go DONE; DONE SHALL assert done one cycle then go IDLE.
REQ-027 start while busy SHALL be ignored.
REQ-028 Latency: start to first elem_valid = 2*FILT_SIZE+1 cycles for zero-wait memory (mem_valid the cycle after mem_rd).
REQ-029 Outside SCAN, elem_valid and elem_last SHALL be 0; outside LOAD_WAIT, fb_ld SHALL be 0.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, counters 0, base 0; all outputs 0 (busy, done, mem_rd, mem_addr, fb_ld, fb_row, fb_col, elem_valid, elem_last); mid-operation reset abandons the transfer with no further fb_ld.

Configuration
REQ-031 With FILTER_CTRL_REUSE_EN defined, start with reuse=1 SHALL go directly to SCAN (no mem_rd); without it, reuse SHALL be ignored and every start loads.

Structure
REQ-032 State encoding enum and FILT_SIZE_MAX=4 SHALL live in shared package filter_pkg.
REQ-033 Scan row/col counting SHALL be a sub-module filter_scan_cnt (enable, clear, size, wrap/last outputs).

Verification
REQ-034 Reset mid-LOAD_WAIT (row 2) -> all outputs 0 immediately, IDLE, later start reloads from row 0.
REQ-035 start, base_addr=0x0100, zero-wait memory, elem_ready=1 -> mem_addr 0x0100..0x0103, fb_ld rows 0..3, 16 elements row-major, done at cycle 26.
REQ-036 base_addr=0xFFFE -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-037 elem_ready low 3 cycles at (1,2) -> fb_row=1, fb_col=2 held, elem_valid held, no skipped element.
REQ-038 FILT_SIZE=2, mem_valid delayed 5 cycles per row, start pulsed during SCAN -> 2 reads, 4 elements, elem_last on (1,1), second start ignored.
REQ-039 FILTER_CTRL_REUSE_EN defined, start with reuse=1 -> no mem_rd, elem_valid next cycle; undefined -> full load.

Source files
------------

// File: rtl/filter_pkg.sv
// filter_pkg: shared definitions for the filter controller.
// Holds the controller state encoding, the maximum filter size and the
// row/col counter width used by filter_ctrl and filter_scan_cnt.
package filter_pkg;

  localparam int unsigned FILT_SIZE_MAX = 4;
  localparam int unsigned CNT_W         = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_REQ  = 3'd1,
    S_LOAD_WAIT = 3'd2,
    S_SCAN      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  // Highest legal row/col index for a given filter size.
  function automatic logic [CNT_W-1:0] size_max_idx(input int unsigned size);
    return CNT_W'(size - 1);
  endfunction

endpackage

// File: rtl/filter_scan_cnt.sv
// filter_scan_cnt: row/col counter pair for the filter controller.
// i_row_inc steps only the row (used while loading rows); i_en steps the
// row-major scan (col first, wrapping into the next row). Both wrap the row
// back to 0 after the last row so the next phase starts from (0,0).
module filter_scan_cnt
  import filter_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_row_inc,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_row,
  output logic [CNT_W-1:0] o_col,
  output logic             o_row_wrap,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] LAST_IDX = size_max_idx(SIZE);

  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic             w_col_wrap;

  assign w_col_wrap = (r_col == LAST_IDX);
  assign o_row_wrap = (r_row == LAST_IDX);
  assign o_last     = o_row_wrap && w_col_wrap;
  assign o_row      = r_row;
  assign o_col      = r_col;

  // Counter update: clear has priority, then row-only step, then scan step.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_row_inc) begin
      r_row <= o_row_wrap ? '0 : r_row + CNT_W'(1);
    end else if (i_en) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= o_row_wrap ? '0 : r_row + CNT_W'(1);
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/filter_ctrl.sv
// filter_ctrl: loads FILT_SIZE row words of a filter from memory into the
// filter buffer, then scans the buffer row-major to a consumer.
// Optional feature macro FILTER_CTRL_REUSE_EN: start with reuse=1 skips the
// load and scans the buffer contents already present.
//
// Handshake: an element transfers on a cycle where elem_valid and elem_ready
// are both high; elem_valid stays high and fb_row/fb_col hold until then.
// mem_rd is a single-cycle request; mem_valid is accepted only in LOAD_WAIT.
module filter_ctrl
  import filter_pkg::*;
#(
  parameter int unsigned FILT_SIZE = 4,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              reuse,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  output logic              fb_ld,
  output logic [1:0]        fb_row,
  output logic [1:0]        fb_col,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic              elem_last,
  output state_t            dbg_state
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;

  logic              w_clear;
  logic              w_row_inc;
  logic              w_scan_en;
  logic              w_reuse_go;
  logic [CNT_W-1:0]  w_row;
  logic [CNT_W-1:0]  w_col;
  logic              w_row_wrap;
  logic              w_last;

`ifdef FILTER_CTRL_REUSE_EN
  assign w_reuse_go = reuse;
`else
  // Without the reuse feature every start performs a full load.
  assign w_reuse_go = reuse & 1'b0;
`endif

  filter_scan_cnt #(
    .SIZE (FILT_SIZE)
  ) u_cnt (
    .clk        (clk),
    .i_rst_n    (rst),
    .i_clear    (w_clear),
    .i_row_inc  (w_row_inc),
    .i_en       (w_scan_en),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_row_wrap (w_row_wrap),
    .o_last     (w_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Base address is captured only when a start is accepted in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             r_base <= '0;
    else if (r_state == S_IDLE && start)  r_base <= base_addr;
  end

  // Next-state and output decode.
  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    w_row_inc  = 1'b0;
    w_scan_en  = 1'b0;
    mem_rd     = 1'b0;
    fb_ld      = 1'b0;
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = w_reuse_go ? S_SCAN : S_LOAD_REQ;
        end
      end
      S_LOAD_REQ: begin
        mem_rd = 1'b1;
        w_next = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        if (mem_valid) begin
          fb_ld     = 1'b1;
          w_row_inc = 1'b1;
          w_next    = w_row_wrap ? S_SCAN : S_LOAD_REQ;
        end
      end
      S_SCAN: begin
        elem_valid = 1'b1;
        elem_last  = w_last;
        if (elem_ready) begin
          w_scan_en = 1'b1;
          if (w_last) w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign mem_addr  = mem_rd ? (r_base + ADDR_W'(w_row)) : '0;
  assign fb_row    = w_row;
  assign fb_col    = w_col;
  assign dbg_state = r_state;

endmodule
